// File: rtl/text_ram_arbiter.sv
// rtl/text_ram_arbiter.sv - display-priority arbiter between video fetch and host writes to text RAM
module text_ram_arbiter #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int AW   = 12,
    parameter int DW   = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pixel_tick,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          host_ack,
    output logic          host_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] char_code,
    output logic          char_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_RD  = 2'd1,
        DISP_LAT = 2'd2,
        HOST_WR  = 2'd3
    } state_t;

    localparam logic [AW-1:0] COLS_W = AW'(COLS);
    localparam logic [31:0]   CELLS  = 32'(COLS * ROWS);

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          acked_q, acked_d;
    logic [AW-1:0] disp_addr_q, disp_addr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          host_ack_q, host_ack_d;
    logic          host_err_q, host_err_d;
    logic [DW-1:0] char_code_q, char_code_d;
    logic          char_valid_q, char_valid_d;

    logic          trigger;
    logic          host_go;
    logic          in_range;
    logic [AW-1:0] disp_addr;

    assign trigger   = pixel_tick & video_on & (pixel_x[2:0] == 3'd0);
    assign disp_addr = AW'(pixel_y[8:4]) * COLS_W + AW'(pixel_x[9:3]);
    assign in_range  = {{(32-AW){1'b0}}, host_addr} < CELLS;
    // A request still held after its ack is masked until the host drops it.
    assign host_go   = host_req & ~acked_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        acked_d      = acked_q & host_req;
        disp_addr_d  = trigger ? disp_addr : disp_addr_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        host_ack_d   = 1'b0;
        host_err_d   = 1'b0;
        char_code_d  = char_code_q;
        char_valid_d = 1'b0;

        if (state_q == DISP_RD) begin
            state_d = DISP_LAT;
            if (trigger) begin
                pend_d = 1'b1;
            end
        end else if (trigger || pend_q) begin
            state_d = DISP_RD;
        end else if (state_q != HOST_WR && host_go) begin
            state_d = HOST_WR;
        end else begin
            state_d = IDLE;
        end

        if (state_q == DISP_LAT) begin
            char_code_d  = ram_rdata;
            char_valid_d = 1'b1;
        end

        // Outputs are registered, so they are set up for the state being entered.
        if (state_d == DISP_RD) begin
            pend_d     = 1'b0;
            ram_addr_d = trigger ? disp_addr : disp_addr_q;
        end else if (state_d == HOST_WR) begin
            ram_addr_d  = host_addr;
            ram_wdata_d = host_data;
            ram_we_d    = in_range;
            host_ack_d  = 1'b1;
            host_err_d  = ~in_range;
            acked_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            acked_q      <= 1'b0;
            disp_addr_q  <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_err_q   <= 1'b0;
            char_code_q  <= '0;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            acked_q      <= acked_d;
            disp_addr_q  <= disp_addr_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            host_ack_q   <= host_ack_d;
            host_err_q   <= host_err_d;
            char_code_q  <= char_code_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_err   = host_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign char_code  = char_code_q;
    assign char_valid = char_valid_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb/tb_text_ram_arbiter.sv - self-checking bench for text_ram_arbiter
module tb_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_tick, video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic        host_req;
    logic [11:0] host_addr;
    logic [6:0]  host_data;
    logic        host_ack, host_err;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [6:0]  ram_wdata;
    logic [6:0]  ram_rdata;
    logic [6:0]  char_code;
    logic        char_valid;

    int checks = 0;
    int failures = 0;
    int we_pulses = 0;
    int ack_pulses = 0;
    logic init_done = 1'b0;

    logic [6:0] mem   [0:4095];
    logic [6:0] model [0:4095];

    always #5 clk = ~clk;

    text_ram_arbiter #(.COLS(80), .ROWS(30), .AW(12), .DW(7)) dut (
        .clk(clk), .reset(reset),
        .pixel_tick(pixel_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .host_err(host_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .char_code(char_code), .char_valid(char_valid)
    );

    function automatic logic [6:0] init_val(input int i);
        return (i == 0) ? 7'h41 : 7'((i * 37 + 11) % 128);
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (init_done) begin
            if (ram_we) we_pulses++;
            if (host_ack) ack_pulses++;
            if (ram_we) begin
                checks++;
                if (host_ack !== 1'b1) begin
                    failures++;
                    $display("FAIL we_outside_host_wr host_ack=%b required=1", host_ack);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_check(input int x, input int y, input string nm);
        int exp_idx;
        exp_idx = (y / 16) * 80 + (x / 8);
        pixel_x = 10'(x); pixel_y = 10'(y);
        pixel_tick = 1'b1; video_on = 1'b1;
        step();
        pixel_tick = 1'b0;
        checks++;
        if (ram_addr !== 12'(exp_idx) || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL %s_addr got=%0d we=%b required=%0d we=0", nm, ram_addr, ram_we, exp_idx);
        end
        step();
        checks++;
        if (char_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_early_valid got=%b required=0", nm, char_valid);
        end
        step();
        checks++;
        if (char_valid !== 1'b1 || char_code !== model[exp_idx]) begin
            failures++;
            $display("FAIL %s_char valid=%b code=%h required valid=1 code=%h", nm, char_valid, char_code, model[exp_idx]);
        end
        step();
        checks++;
        if (char_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid_pulse got=%b required=0", nm, char_valid);
        end
    endtask

    task automatic wait_ack(input string nm);
        for (int i = 0; i < 12; i++) begin
            if (host_ack) break;
            step();
        end
        checks++;
        if (host_ack !== 1'b1) begin
            failures++;
            $display("FAIL %s_ack_timeout got=%b required=1", nm, host_ack);
        end
    endtask

    task automatic host_write(input int addr, input logic [6:0] data, input string nm);
        logic exp_err;
        exp_err = (addr >= 2400);
        host_addr = 12'(addr); host_data = data; host_req = 1'b1;
        step();
        wait_ack(nm);
        checks++;
        if (host_err !== exp_err || ram_we !== !exp_err || ram_addr !== 12'(addr)) begin
            failures++;
            $display("FAIL %s_wr err=%b we=%b addr=%0d required err=%b we=%b addr=%0d",
                     nm, host_err, ram_we, ram_addr, exp_err, !exp_err, addr);
        end
        if (!exp_err) model[addr] = data;
        host_req = 1'b0;
        step();
        checks++;
        if (host_ack !== 1'b0 || host_err !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse ack=%b err=%b we=%b required 0 0 0", nm, host_ack, host_err, ram_we);
        end
    endtask

    task automatic test_reset;
        step();
        checks++;
        if ({host_ack, host_err, ram_we, char_valid} !== 4'b0 || ram_addr !== 12'd0 ||
            ram_wdata !== 7'd0 || char_code !== 7'd0) begin
            failures++;
            $display("FAIL reset_state ack=%b err=%b we=%b cv=%b addr=%0d wd=%h cc=%h required all 0",
                     host_ack, host_err, ram_we, char_valid, ram_addr, ram_wdata, char_code);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch;
        fetch_check(0, 0, "basic");
        checks++;
        if (char_code !== 7'h41) begin
            failures++;
            $display("FAIL basic_41 got=%h required=41", char_code);
        end
    endtask

    task automatic test_corner_addr;
        fetch_check(632, 479, "corner");
    endtask

    task automatic test_host_with_trigger;
        pixel_x = 10'd0; pixel_y = 10'd0; pixel_tick = 1'b1; video_on = 1'b1;
        host_addr = 12'd5; host_data = 7'h5A; host_req = 1'b1;
        step();
        pixel_tick = 1'b0;
        checks++;
        if (ram_addr !== 12'd0 || host_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_t1 addr=%0d ack=%b required addr=0 ack=0", ram_addr, host_ack);
        end
        step();
        checks++;
        if (host_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_t2 ack=%b required=0", host_ack);
        end
        step();
        checks++;
        if (host_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'd5 || ram_wdata !== 7'h5A ||
            char_valid !== 1'b1) begin
            failures++;
            $display("FAIL prio_t3 ack=%b we=%b addr=%0d wd=%h cv=%b required 1 1 5 5a 1",
                     host_ack, ram_we, ram_addr, ram_wdata, char_valid);
        end
        model[5] = 7'h5A;
        host_req = 1'b0;
        step();
        step();
        fetch_check(40, 0, "readback5");
    endtask

    task automatic test_held_req;
        int we0, ack0;
        we0 = we_pulses; ack0 = ack_pulses;
        host_addr = 12'd10; host_data = 7'h33; host_req = 1'b1;
        step();
        wait_ack("held");
        model[10] = 7'h33;
        repeat (4) step();
        host_req = 1'b0;
        repeat (3) step();
        checks++;
        if (we_pulses - we0 != 1 || ack_pulses - ack0 != 1) begin
            failures++;
            $display("FAIL held_once we=%0d ack=%0d required 1 1", we_pulses - we0, ack_pulses - ack0);
        end
        fetch_check(80, 0, "held_rb");
    endtask

    task automatic test_out_of_range;
        host_write(2400, 7'h7F, "oor");
        checks++;
        if (mem[2400] !== model[2400]) begin
            failures++;
            $display("FAIL oor_ram got=%h required=%h", mem[2400], model[2400]);
        end
    endtask

    task automatic test_no_fetch;
        logic [6:0] held;
        held = char_code;
        pixel_x = 10'd16; pixel_y = 10'd0; video_on = 1'b0; pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        step();
        pixel_x = 10'd17; video_on = 1'b1; pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (char_valid !== 1'b0 || char_code !== held) begin
                failures++;
                $display("FAIL no_fetch cv=%b cc=%h required cv=0 cc=%h", char_valid, char_code, held);
            end
            step();
        end
    endtask

    task automatic test_back_to_back;
        int ia, ib;
        ia = 3 * 80 + 7; ib = 3 * 80 + 8;
        pixel_x = 10'd56; pixel_y = 10'd48; video_on = 1'b1; pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        step();
        pixel_x = 10'd64; pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        checks++;
        if (char_valid !== 1'b1 || char_code !== model[ia] || ram_addr !== 12'(ib)) begin
            failures++;
            $display("FAIL b2b_first cv=%b cc=%h addr=%0d required 1 %h %0d",
                     char_valid, char_code, ram_addr, model[ia], ib);
        end
        step();
        step();
        checks++;
        if (char_valid !== 1'b1 || char_code !== model[ib]) begin
            failures++;
            $display("FAIL b2b_second cv=%b cc=%h required 1 %h", char_valid, char_code, model[ib]);
        end
        step();
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                fetch_check(8 * $urandom_range(0, 79), 16 * $urandom_range(0, 29) + $urandom_range(0, 15), "rnd_fetch");
            end else begin
                host_write(($urandom_range(0, 7) == 0) ? $urandom_range(2400, 4095) : $urandom_range(0, 2399),
                           7'($urandom), "rnd_write");
            end
        end
    endtask

    task automatic test_reset_mid_write;
        host_addr = 12'd81; host_data = ~model[81]; host_req = 1'b1;
        step();
        checks++;
        if (host_ack !== 1'b1 || ram_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_wr_enter ack=%b we=%b required 1 1", host_ack, ram_we);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({host_ack, host_err, ram_we, char_valid} !== 4'b0 || ram_addr !== 12'd0 ||
            ram_wdata !== 7'd0 || char_code !== 7'd0) begin
            failures++;
            $display("FAIL rst_async ack=%b err=%b we=%b cv=%b addr=%0d wd=%h cc=%h required all 0",
                     host_ack, host_err, ram_we, char_valid, ram_addr, ram_wdata, char_code);
        end
        host_req = 1'b0;
        step();
        step();
        checks++;
        if (mem[81] !== model[81]) begin
            failures++;
            $display("FAIL rst_no_write got=%h required=%h", mem[81], model[81]);
        end
        reset = 1'b1;
        step();
        fetch_check(8, 16, "post_reset");
    endtask

    initial begin
        reset = 1'b0;
        pixel_tick = 1'b0; video_on = 1'b0;
        pixel_x = '0; pixel_y = '0;
        host_req = 1'b0; host_addr = '0; host_data = '0;
        for (int i = 0; i < 4096; i++) model[i] = init_val(i);
        @(posedge clk);
        #1 init_done = 1'b1;
        test_reset();
        test_basic_fetch();
        test_corner_addr();
        test_host_with_trigger();
        test_held_req();
        test_out_of_range();
        test_no_fetch();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
